// File: rtl/fsb_pkg.sv
// fsb_pkg: shared front-side-bus types, defaults and chip-select priority.
package fsb_pkg;
  localparam int FSB_ROMWS = 2;
  localparam int FSB_TIMEOUT = 255;
  localparam int FSB_CNTW = 8;
  typedef enum logic [2:0] {
    S_IDLE, S_AVEC, S_IOWAIT, S_ROMWAIT, S_RAMWAIT, S_NOSEL, S_TERM
  } fsb_state_t;
  typedef enum logic [2:0] {
    SEL_NONE, SEL_IACK, SEL_IO, SEL_ROM, SEL_RAM
  } fsb_sel_t;
  // IOCS beats RAMCS so video-RAM writes go through the IOB bridge
  function automatic fsb_sel_t fsb_sel(input logic iacs, input logic iocs,
                                       input logic romcs, input logic ramcs);
    if (iacs) return SEL_IACK;
    if (iocs) return SEL_IO;
    if (romcs) return SEL_ROM;
    if (ramcs) return SEL_RAM;
    return SEL_NONE;
  endfunction
endpackage

// File: rtl/fsb_wdt.sv
// fsb_wdt: loadable saturating up/down counter with clear, enable and expired flag.
module fsb_wdt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [W-1:0] val_i,
  input  logic [W-1:0] lim_i,
  output logic         exp_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr_i ? '0 :
            ld_i  ? val_i :
            !en_i ? cnt_q :
            up_i  ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) :
                    ((cnt_q == '0) ? cnt_q : cnt_q - 1'b1);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign exp_o = up_i ? (cnt_q >= lim_i) : (cnt_q == '0);
endmodule

// File: rtl/fsb_term.sv
// fsb_term: MC68HC000 bus-cycle terminator driving nDTACK/nVPA/nBERR and IOB/RAM requests.
module fsb_term
  import fsb_pkg::*;
#(
  parameter int ROMWS   = FSB_ROMWS,
  parameter int TIMEOUT = FSB_TIMEOUT,
  parameter int CNTW    = FSB_CNTW
) (
  input  logic CLK,
  input  logic RES,
  input  logic ASActive,
  input  logic ASInactive,
  input  logic RAMCS,
  input  logic ROMCS,
  input  logic IOCS,
  input  logic IACS,
  input  logic RAMReady,
  input  logic IOACK,
  output logic IOREQ,
  output logic RAMREQ,
  output logic nDTACK,
  output logic nVPA,
  output logic nBERR
);
  // ROM count is preloaded one short: entering ROMWAIT already consumes a cycle
  localparam logic [CNTW-1:0] ROM_LD = CNTW'(ROMWS > 0 ? ROMWS - 1 : 0);
  localparam logic [CNTW-1:0] WDT_LIM = CNTW'(TIMEOUT - 1);
  fsb_state_t state_q, state_d;
  fsb_sel_t sel;
  logic ioreq_q, ioreq_d, ramreq_q, ramreq_d;
  logic dtack_n_q, dtack_n_d, vpa_n_q, vpa_n_d, berr_n_q, berr_n_d;
  logic clr, ld, en, up, expd, ack, start;
  assign sel = fsb_sel(IACS, IOCS, ROMCS, RAMCS);
  assign start = ASActive && !ASInactive;
  assign up = state_q != S_ROMWAIT;
  assign ack = state_q == S_IOWAIT ? IOACK : state_q == S_RAMWAIT ? RAMReady : 1'b0;
  fsb_wdt #(.W(CNTW)) u_wdt (
    .clk_i(CLK),
    .rst_i(RES),
    .clr_i(clr),
    .ld_i (ld),
    .en_i (en),
    .up_i (up),
    .val_i(ROM_LD),
    .lim_i(WDT_LIM),
    .exp_o(expd)
  );
  always_comb begin
    state_d = state_q;
    ioreq_d = ioreq_q;
    ramreq_d = ramreq_q;
    dtack_n_d = dtack_n_q;
    vpa_n_d = vpa_n_q;
    berr_n_d = berr_n_q;
    clr = 1'b0;
    ld = 1'b0;
    en = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        clr = sel != SEL_ROM;
        ld = sel == SEL_ROM;
        case (sel)
          SEL_IACK: begin state_d = S_AVEC; vpa_n_d = 1'b0; end
          SEL_IO:   begin state_d = S_IOWAIT; ioreq_d = 1'b1; end
          SEL_RAM:  begin state_d = S_RAMWAIT; ramreq_d = 1'b1; end
          SEL_ROM:  if (ROMWS == 0) begin state_d = S_TERM; dtack_n_d = 1'b0; end
                    else state_d = S_ROMWAIT;
          default:  state_d = S_NOSEL;
        endcase
      end
      S_AVEC, S_TERM: if (ASInactive) begin
        state_d = S_IDLE;
        dtack_n_d = 1'b1;
        vpa_n_d = 1'b1;
        berr_n_d = 1'b1;
      end
      default: begin
        // abort beats ack, ack beats watchdog expiry
        if (ASInactive) begin
          state_d = S_IDLE;
          ioreq_d = 1'b0;
          ramreq_d = 1'b0;
        end else if (ack || expd) begin
          state_d = S_TERM;
          ioreq_d = 1'b0;
          ramreq_d = 1'b0;
          dtack_n_d = !(ack || state_q == S_ROMWAIT);
          berr_n_d = ack || state_q == S_ROMWAIT;
        end else en = 1'b1;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= S_IDLE;
      ioreq_q <= 1'b0;
      ramreq_q <= 1'b0;
      dtack_n_q <= 1'b1;
      vpa_n_q <= 1'b1;
      berr_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ioreq_q <= ioreq_d;
      ramreq_q <= ramreq_d;
      dtack_n_q <= dtack_n_d;
      vpa_n_q <= vpa_n_d;
      berr_n_q <= berr_n_d;
    end
  end
  assign IOREQ = ioreq_q;
  assign RAMREQ = ramreq_q;
  assign nDTACK = dtack_n_q;
  assign nVPA = vpa_n_q;
  assign nBERR = berr_n_q;
endmodule
